// File: rtl/io_intr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_intr_ctrl : edge-triggered interrupt controller with CPU register port
// Rev 1.0
// ----------------------------------------------------------------------------
module io_intr_ctrl #(
  parameter int          NUM_SRC  = 4,
  parameter logic [31:0] MASK_RST = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               io_cs,
  input  logic               io_rd,
  input  logic               io_wr,
  input  logic [31:0]        io_address,
  input  logic [31:0]        io_d_in,
  output logic [31:0]        io_out,
  input  logic               inta,
  output logic               intr
);

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_VEC  = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] mask;
  logic               en;
  logic               vec_valid;
  logic [4:0]         vec_idx;

  logic               wr;
  logic [1:0]         sel;
  logic [NUM_SRC-1:0] edge_evt;
  logic [NUM_SRC-1:0] pm;
  logic               pm_any;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] win_oh;
  logic [4:0]         win_idx;
  logic               ack_fire;
  logic               rd_en;
  logic [31:0]        rd_data;
  logic               unused;

  assign wr       = io_cs & io_wr;
  assign sel      = io_address[3:2];
  assign edge_evt = irq_src & ~prev;
  assign pm       = pend & mask;
  assign pm_any   = |pm;
  assign w1c      = (wr && sel == A_PEND) ? io_d_in[NUM_SRC-1:0] : '0;
  assign ack_fire = (state == REQ) && inta && en && pm_any;
  assign ack_clr  = ack_fire ? win_oh : '0;
  assign unused   = ^{io_address[31:4], io_address[1:0], io_d_in[31:NUM_SRC]};

  // Fixed priority: scanning downward leaves the lowest set index as winner.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pm[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_idx   = 5'(i);
      end
    end
  end

  // A fresh edge on a bit overrides a clear of that bit in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
      pend <= '0;
    end else begin
      prev <= irq_src;
      pend <= (pend & ~w1c & ~ack_clr) | edge_evt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= MASK_RST[NUM_SRC-1:0];
      en   <= 1'b0;
    end else if (wr) begin
      if (sel == A_MASK) mask <= io_d_in[NUM_SRC-1:0];
      if (sel == A_CTRL) en   <= io_d_in[0];
    end
  end

  // Request/acknowledge handshake; intr is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      intr      <= 1'b0;
      vec_valid <= 1'b0;
      vec_idx   <= '0;
    end else begin
      if (wr && sel == A_VEC) vec_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && pm_any) begin
            state <= REQ;
            intr  <= 1'b1;
          end
        end
        REQ: begin
          if (!en || !pm_any) begin
            state <= IDLE;
            intr  <= 1'b0;
          end else if (inta) begin
            state     <= ACK;
            intr      <= 1'b0;
            vec_idx   <= win_idx;
            vec_valid <= 1'b1;
          end
        end
        ACK: begin
          if (!inta) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          intr  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (sel)
      A_PEND:  rd_data[NUM_SRC-1:0] = pend;
      A_MASK:  rd_data[NUM_SRC-1:0] = mask;
      A_VEC:   rd_data = {vec_valid, 26'b0, vec_idx};
      A_CTRL:  rd_data = {31'b0, en};
      default: rd_data = '0;
    endcase
  end

  assign rd_en  = io_cs & io_rd & ~io_wr;
  assign io_out = rd_en ? rd_data : 32'hz;

endmodule
`default_nettype wire

// File: tb/tb_io_intr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_io_intr_ctrl : directed self-checking bench for io_intr_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_io_intr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_src;
  logic        io_cs;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_address;
  logic [31:0] io_d_in;
  wire  [31:0] io_out;
  logic        inta;
  wire         intr;

  int n_cmp = 0;
  int n_err = 0;

  io_intr_ctrl #(.NUM_SRC(4), .MASK_RST(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .io_cs      (io_cs),
    .io_rd      (io_rd),
    .io_wr      (io_wr),
    .io_address (io_address),
    .io_d_in    (io_d_in),
    .io_out     (io_out),
    .inta       (inta),
    .intr       (intr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    io_cs = 1'b1; io_rd = 1'b1; io_address = {28'h0, a, 2'b00};
    #1;
    d = io_out;
    io_cs = 1'b0; io_rd = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    io_cs = 1'b1; io_wr = 1'b1; io_address = {28'h0, a, 2'b00}; io_d_in = d;
    tick();
    io_cs = 1'b0; io_wr = 1'b0; io_d_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; irq_src = '0; io_cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
    io_address = '0; io_d_in = '0; inta = 1'b0;
    repeat (2) tick();
    chk("rst_intr", {31'b0, intr}, 32'h0);
    reset = 1'b0;
    rd_chk("rst_pend", 2'd0, 32'h0);
    rd_chk("rst_mask", 2'd1, 32'h0);
    rd_chk("rst_vec",  2'd2, 32'h0);
    rd_chk("rst_ctrl", 2'd3, 32'h0);

    // Unimplemented bits read back as zero
    wr(2'd3, 32'hFFFF_FFFF);
    rd_chk("ctrl_bits", 2'd3, 32'h1);
    wr(2'd1, 32'hFFFF_FFFF);
    rd_chk("mask_bits", 2'd1, 32'hF);
    wr(2'd2, 32'hFFFF_FFFF);
    rd_chk("vec_ro", 2'd2, 32'h0);

    // Single source 2 event through full handshake
    irq_src = 4'b0100; tick(); irq_src = '0;
    rd_chk("s2_pend", 2'd0, 32'h4);
    chk("s2_intr_lat", {31'b0, intr}, 32'h0);
    tick();
    chk("s2_intr", {31'b0, intr}, 32'h1);
    inta = 1'b1; tick();
    chk("s2_ack_intr", {31'b0, intr}, 32'h0);
    rd_chk("s2_vec", 2'd2, 32'h8000_0002);
    rd_chk("s2_pend_clr", 2'd0, 32'h0);
    inta = 1'b0; tick(); tick();
    chk("s2_idle", {31'b0, intr}, 32'h0);
    wr(2'd2, 32'h0);
    rd_chk("vec_clr", 2'd2, 32'h0000_0002);

    // Simultaneous sources 3 and 1: priority to 1, then 3
    irq_src = 4'b1010; tick(); irq_src = '0;
    tick();
    chk("p_intr1", {31'b0, intr}, 32'h1);
    inta = 1'b1; tick();
    rd_chk("p_vec1", 2'd2, 32'h8000_0001);
    rd_chk("p_pend1", 2'd0, 32'h8);
    tick();
    chk("p_ack_hold", {31'b0, intr}, 32'h0);
    inta = 1'b0; tick();
    chk("p_idle", {31'b0, intr}, 32'h0);
    tick();
    chk("p_intr2", {31'b0, intr}, 32'h1);
    inta = 1'b1; tick();
    rd_chk("p_vec2", 2'd2, 32'h8000_0003);
    rd_chk("p_pend2", 2'd0, 32'h0);
    inta = 1'b0; tick();

    // Masked event pends but does not request until unmasked
    wr(2'd1, 32'h0);
    irq_src = 4'b0001; tick(); irq_src = '0;
    rd_chk("m_pend", 2'd0, 32'h1);
    tick(); tick();
    chk("m_noreq", {31'b0, intr}, 32'h0);
    wr(2'd1, 32'h1);
    chk("m_lat", {31'b0, intr}, 32'h0);
    tick();
    chk("m_req", {31'b0, intr}, 32'h1);

    // W1C of the only pending bit withdraws the request
    wr(2'd0, 32'h1);
    rd_chk("w1c_pend", 2'd0, 32'h0);
    tick();
    chk("w1c_intr", {31'b0, intr}, 32'h0);
    tick();
    chk("w1c_idle", {31'b0, intr}, 32'h0);

    // New edge coincident with the acknowledge of the same bit survives
    irq_src = 4'b0001; tick(); irq_src = '0;
    tick();
    chk("c_req", {31'b0, intr}, 32'h1);
    inta = 1'b1; irq_src = 4'b0001; tick();
    rd_chk("c_pend", 2'd0, 32'h1);
    rd_chk("c_vec", 2'd2, 32'h8000_0000);
    chk("c_ack", {31'b0, intr}, 32'h0);
    irq_src = '0; inta = 1'b0; tick(); tick();
    chk("c_rereq", {31'b0, intr}, 32'h1);

    // Reset while in ACK with inta held high
    inta = 1'b1; tick();
    chk("r_ack", {31'b0, intr}, 32'h0);
    reset = 1'b1; #1;
    chk("r_intr", {31'b0, intr}, 32'h0);
    rd_chk("r_pend", 2'd0, 32'h0);
    rd_chk("r_mask", 2'd1, 32'h0);
    rd_chk("r_vec",  2'd2, 32'h0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("r_inta_ign", {31'b0, intr}, 32'h0);
    wr(2'd3, 32'h1);
    wr(2'd1, 32'hF);
    tick();
    chk("r_noreq", {31'b0, intr}, 32'h0);
    irq_src = 4'b1000; tick(); irq_src = '0;
    tick();
    chk("r_newreq", {31'b0, intr}, 32'h1);
    tick();
    rd_chk("r_vec3", 2'd2, 32'h8000_0003);
    chk("r_ack3", {31'b0, intr}, 32'h0);
    inta = 1'b0; tick();

    // Level already high at reset release counts as an edge
    reset = 1'b1; irq_src = 4'b0010; tick();
    reset = 1'b0;
    rd_chk("hi_pend0", 2'd0, 32'h0);
    tick();
    rd_chk("hi_pend1", 2'd0, 32'h2);
    irq_src = '0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
